// File: rtl/serial_bus_pkg.sv
// Shared types and default widths for the serial bus slave endpoint.
package serial_bus_pkg;

    localparam int SSP_ADDR_W = 12;
    localparam int SSP_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WCOMMIT,
        RFETCH,
        RDATA
    } ssp_state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_WR,
        OP_RD
    } ssp_op_t;

endpackage

// File: rtl/serial_slave_mem.sv
// Single-port synchronous RAM, 2**ADDR_W x DATA_W, one-cycle read latency.
module serial_slave_mem #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array has no reset branch so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/serial_slave_port.sv
// Serial bus slave endpoint: deserialises address/write data, accesses local RAM, serialises read data.
// Defining SERIAL_SLAVE_PARITY_EN adds an even-parity bit after every data word and the PARITY_ERR output.
module serial_slave_port
    import serial_bus_pkg::*;
#(
    parameter int ADDR_W = SSP_ADDR_W,
    parameter int DATA_W = SSP_DATA_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic M_VALID,
    input  logic M_READY,
    input  logic RX_ADDR,
    input  logic RX_DATA,
    input  logic WRITE_EN,
    input  logic READ_EN,
    input  logic RX_BURST,
    output logic DATA_TX,
    output logic SLAVE_READY,
    output logic SLAVE_VALID
`ifdef SERIAL_SLAVE_PARITY_EN
    ,
    output logic PARITY_ERR
`endif
);

`ifdef SERIAL_SLAVE_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int MAXB  = (ADDR_W > NBITS) ? ADDR_W : NBITS;
    localparam int CNT_W = $clog2(MAXB + 1);

    ssp_state_t        state_q, state_d;
    ssp_op_t           op_q, op_d;
    logic              burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NBITS-1:0]  rx_q, rx_d;
    logic [NBITS-1:0]  tx_q, tx_d;
    logic              slave_ready_q, slave_valid_q;

    logic              in_xfer, out_xfer, word_ok, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [NBITS-1:0]  tx_load;

    assign in_xfer  = M_VALID & slave_ready_q;
    assign out_xfer = slave_valid_q & M_READY;

`ifdef SERIAL_SLAVE_PARITY_EN
    logic parity_err_q;
    assign word_ok    = ~^rx_q;
    assign tx_load    = {^mem_rdata, mem_rdata};
    assign PARITY_ERR = parity_err_q;
`else
    assign word_ok = 1'b1;
    assign tx_load = mem_rdata;
`endif

    // Reads are issued with the next address so the word is ready by the end of RFETCH.
    assign mem_addr = (state_q == WCOMMIT) ? addr_q : addr_d;
    assign mem_we   = (state_q == WCOMMIT) && !RST && word_ok;

    serial_slave_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (rx_q[DATA_W-1:0]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default up front, so no path through the case infers a latch.
        state_d = state_q;
        op_d    = op_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                op_d = OP_NONE;
                if (in_xfer && (WRITE_EN ^ READ_EN)) begin
                    op_d      = WRITE_EN ? OP_WR : OP_RD;
                    burst_d   = RX_BURST;
                    addr_d    = '0;
                    addr_d[0] = RX_ADDR;
                    cnt_d     = CNT_W'(1);
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (in_xfer) begin
                    addr_d[cnt_q] = RX_ADDR;
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        cnt_d   = '0;
                        state_d = (op_q == OP_WR) ? WDATA : RFETCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WDATA: begin
                if (in_xfer) begin
                    rx_d = {RX_DATA, rx_q[NBITS-1:1]};
                    if (cnt_q == CNT_W'(NBITS - 1)) begin
                        cnt_d   = '0;
                        state_d = WCOMMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WCOMMIT: begin
                if (burst_q && M_VALID) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = WDATA;
                end else begin
                    state_d = IDLE;
                end
            end
            RFETCH: begin
                tx_d    = tx_load;
                cnt_d   = '0;
                state_d = RDATA;
            end
            RDATA: begin
                if (out_xfer) begin
                    tx_d = {1'b0, tx_q[NBITS-1:1]};
                    if (cnt_q == CNT_W'(NBITS - 1)) begin
                        cnt_d = '0;
                        if (burst_q && M_VALID) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = RFETCH;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            op_q          <= OP_NONE;
            burst_q       <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            rx_q          <= '0;
            tx_q          <= '0;
            slave_ready_q <= 1'b1;
            slave_valid_q <= 1'b0;
`ifdef SERIAL_SLAVE_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            burst_q       <= burst_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            slave_ready_q <= (state_d inside {IDLE, ADDR, WDATA});
            slave_valid_q <= (state_d == RDATA);
`ifdef SERIAL_SLAVE_PARITY_EN
            parity_err_q  <= (state_d == WCOMMIT) && (^rx_d);
`endif
        end
    end

    assign DATA_TX     = tx_q[0];
    assign SLAVE_READY = slave_ready_q;
    assign SLAVE_VALID = slave_valid_q;

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed self-checking bench for serial_slave_port; honours SERIAL_SLAVE_PARITY_EN when defined.
module tb_serial_slave_port;

`ifdef SERIAL_SLAVE_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic M_VALID = 1'b0, M_READY = 1'b1, RX_ADDR = 1'b0, RX_DATA = 1'b0;
    logic WRITE_EN = 1'b0, READ_EN = 1'b0, RX_BURST = 1'b0;
    logic DATA_TX, SLAVE_READY, SLAVE_VALID;
`ifdef SERIAL_SLAVE_PARITY_EN
    logic PARITY_ERR;
`endif

    int tests = 0;
    int fails = 0;

    serial_slave_port dut (
        .CLK         (CLK),
        .RST         (RST),
        .M_VALID     (M_VALID),
        .M_READY     (M_READY),
        .RX_ADDR     (RX_ADDR),
        .RX_DATA     (RX_DATA),
        .WRITE_EN    (WRITE_EN),
        .READ_EN     (READ_EN),
        .RX_BURST    (RX_BURST),
        .DATA_TX     (DATA_TX),
        .SLAVE_READY (SLAVE_READY),
        .SLAVE_VALID (SLAVE_VALID)
`ifdef SERIAL_SLAVE_PARITY_EN
        ,
        .PARITY_ERR  (PARITY_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Writes n consecutive words starting at a (burst when n>1); flip corrupts the parity bit.
    task automatic do_write(input logic [11:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input bit flip, input string name);
        logic [7:0] d;
        M_VALID = 1; WRITE_EN = 1; READ_EN = 0; RX_BURST = (n > 1); RX_ADDR = a[0];
        tick();
        WRITE_EN = 0; RX_BURST = 0;
        for (int i = 1; i < 12; i++) begin
            RX_ADDR = a[i];
            tick();
        end
        for (int w = 0; w < n; w++) begin
            d = (w == 0) ? d0 : (w == 1) ? d1 : d2;
            for (int i = 0; i < 8; i++) begin
                RX_DATA = d[i];
                tick();
            end
`ifdef SERIAL_SLAVE_PARITY_EN
            RX_DATA = (^d) ^ flip;
            tick();
`endif
            tests++;
            if (SLAVE_READY !== 1'b0) begin
                fails++; $display("FAIL %s commit_ready w%0d: got %b want 0", name, w, SLAVE_READY);
            end
`ifdef SERIAL_SLAVE_PARITY_EN
            tests++;
            if (PARITY_ERR !== flip) begin
                fails++; $display("FAIL %s parity_err_commit: got %b want %b", name, PARITY_ERR, flip);
            end
`endif
            M_VALID = (w < n - 1);
            tick();
            tests++;
            if (SLAVE_READY !== 1'b1) begin
                fails++; $display("FAIL %s post_commit_ready w%0d: got %b want 1", name, w, SLAVE_READY);
            end
`ifdef SERIAL_SLAVE_PARITY_EN
            tests++;
            if (PARITY_ERR !== 1'b0) begin
                fails++; $display("FAIL %s parity_err_after: got %b want 0", name, PARITY_ERR);
            end
`endif
        end
        M_VALID = 0;
    endtask

    // Reads n words from a; stall toggles M_READY 1,0,0,..; gaps drops M_VALID inside the address phase.
    task automatic do_read(input logic [11:0] a, input int n, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input bit stall, input bit gaps, input string name);
        logic [7:0]    exp_w;
        logic [NB-1:0] exp_bits, got;
        logic          held;
        int            k, b, nb, cyc;
        M_VALID = 1; READ_EN = 1; WRITE_EN = 0; RX_BURST = (n > 1); RX_ADDR = a[0];
        tick();
        READ_EN = 0; RX_BURST = 0;
        for (int i = 1; i < 12; i++) begin
            if (gaps && (i == 4 || i == 8)) begin
                M_VALID = 0; RX_ADDR = ~a[i];
                tick();
                M_VALID = 1;
            end
            RX_ADDR = a[i];
            tick();
        end
        tests++;
        if (SLAVE_VALID !== 1'b0 || SLAVE_READY !== 1'b0) begin
            fails++; $display("FAIL %s rfetch: valid %b ready %b want 0 0", name, SLAVE_VALID, SLAVE_READY);
        end
        k = 0;
        for (int w = 0; w < n; w++) begin
            exp_w = (w == 0) ? e0 : (w == 1) ? e1 : e2;
`ifdef SERIAL_SLAVE_PARITY_EN
            exp_bits = {^exp_w, exp_w};
`else
            exp_bits = exp_w;
`endif
            M_VALID = (w < n - 1);
            b = 0;
            while (SLAVE_VALID !== 1'b1 && b < 4) begin
                tick();
                b++;
            end
            tests++;
            if (b != 1) begin
                fails++; $display("FAIL %s valid_latency w%0d: got %0d cycles want 1", name, w, b);
            end
            got = '0; nb = 0; cyc = 0;
            while (nb < NB && cyc < 64) begin
                M_READY = stall ? (k % 3 == 0) : 1'b1;
                k++;
                if (SLAVE_VALID === 1'b1 && M_READY) begin
                    got[nb] = DATA_TX;
                    nb++;
                    tick();
                end else begin
                    held = DATA_TX;
                    tick();
                    tests++;
                    if (DATA_TX !== held) begin
                        fails++; $display("FAIL %s stall_hold: got %b want %b", name, DATA_TX, held);
                    end
                end
                cyc++;
            end
            tests++;
            if (got !== exp_bits) begin
                fails++; $display("FAIL %s word%0d: got %h want %h", name, w, got, exp_bits);
            end
        end
        M_READY = 1; M_VALID = 0;
        tests++;
        if (SLAVE_VALID !== 1'b0) begin
            fails++; $display("FAIL %s end_valid: got %b want 0", name, SLAVE_VALID);
        end
    endtask

    task automatic test_reset();
        RST = 1;
        tick(); tick();
        tests++;
        if (DATA_TX !== 1'b0 || SLAVE_VALID !== 1'b0 || SLAVE_READY !== 1'b1) begin
            fails++; $display("FAIL reset_outputs: tx %b valid %b ready %b want 0 0 1", DATA_TX, SLAVE_VALID, SLAVE_READY);
        end
`ifdef SERIAL_SLAVE_PARITY_EN
        tests++;
        if (PARITY_ERR !== 1'b0) begin
            fails++; $display("FAIL reset_parity_err: got %b want 0", PARITY_ERR);
        end
`endif
        RST = 0;
        tick();
    endtask

    task automatic test_write_read();
        do_write(12'h123, 1, 8'hA5, 8'h00, 8'h00, 1'b0, "wr_a5");
        do_read(12'h123, 1, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, "rd_a5");
    endtask

    task automatic test_burst_wrap();
        do_write(12'hFFE, 3, 8'h11, 8'h22, 8'h33, 1'b0, "burst_wr");
        do_read(12'hFFE, 1, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, "rd_ffe");
        do_read(12'hFFF, 1, 8'h22, 8'h00, 8'h00, 1'b0, 1'b0, "rd_fff");
        do_read(12'h000, 1, 8'h33, 8'h00, 8'h00, 1'b0, 1'b0, "rd_000");
    endtask

    task automatic test_back_pressure();
        do_read(12'h123, 1, 8'hA5, 8'h00, 8'h00, 1'b1, 1'b1, "rd_stall");
    endtask

    task automatic test_back_to_back();
        do_read(12'hFFE, 3, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, "burst_rd");
    endtask

    task automatic test_illegal();
        M_VALID = 1; WRITE_EN = 1; READ_EN = 1; RX_ADDR = 1; RX_DATA = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (SLAVE_READY !== 1'b1 || SLAVE_VALID !== 1'b0) begin
                fails++; $display("FAIL illegal_both: ready %b valid %b want 1 0", SLAVE_READY, SLAVE_VALID);
            end
        end
        WRITE_EN = 0; READ_EN = 0;
        tick();
        tests++;
        if (SLAVE_READY !== 1'b1 || SLAVE_VALID !== 1'b0) begin
            fails++; $display("FAIL illegal_none: ready %b valid %b want 1 0", SLAVE_READY, SLAVE_VALID);
        end
        M_VALID = 0; RX_DATA = 0;
        tick();
        do_read(12'h123, 1, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, "rd_after_illegal");
    endtask

    task automatic test_reset_mid_write();
        logic [11:0] a = 12'h010;
        logic [7:0]  d = 8'h7E;
        do_write(a, 1, 8'h5C, 8'h00, 8'h00, 1'b0, "wr_prior");
        M_VALID = 1; WRITE_EN = 1; RX_ADDR = a[0];
        tick();
        WRITE_EN = 0;
        for (int i = 1; i < 12; i++) begin
            RX_ADDR = a[i];
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            RX_DATA = d[i];
            tick();
        end
        RST = 1; M_VALID = 0;
        tick();
        tests++;
        if (SLAVE_READY !== 1'b1 || SLAVE_VALID !== 1'b0 || DATA_TX !== 1'b0) begin
            fails++; $display("FAIL rst_mid_write: ready %b valid %b tx %b want 1 0 0", SLAVE_READY, SLAVE_VALID, DATA_TX);
        end
        RST = 0;
        tick();
        do_read(a, 1, 8'h5C, 8'h00, 8'h00, 1'b0, 1'b0, "rd_after_rst");
    endtask

`ifdef SERIAL_SLAVE_PARITY_EN
    task automatic test_parity();
        do_write(12'h200, 1, 8'h55, 8'h00, 8'h00, 1'b0, "par_prior");
        do_write(12'h200, 1, 8'h03, 8'h00, 8'h00, 1'b1, "par_bad");
        do_read(12'h200, 1, 8'h55, 8'h00, 8'h00, 1'b0, 1'b0, "rd_par_bad");
        do_write(12'h200, 1, 8'h03, 8'h00, 8'h00, 1'b0, "par_good");
        do_read(12'h200, 1, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, "rd_par_good");
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_burst_wrap();
        test_back_pressure();
        test_back_to_back();
        test_illegal();
        test_reset_mid_write();
`ifdef SERIAL_SLAVE_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_slave_port.md
Name: serial_slave_port

Overview:
- Slave-side endpoint of the serial bus.
- Deserialises address and write data from the granted master, writes to or reads from a local memory, and serialises read data back.
- Sits behind the interconnect multiplexer on one Sx_* port group; one instance per slave.

Parameters:
ADDR_W, 12, address width in bits; also sets memory depth 2**ADDR_W
DATA_W, 8, data word width in bits

Ports:
CLK  in  1  bus clock (interconnect-forwarded master clock)
RST  in  1  reset, synchronous, active-high
M_VALID  in  1  master valid; qualifies RX_ADDR/RX_DATA bits
M_READY  in  1  master ready; advances DATA_TX bits
RX_ADDR  in  1  serial address, LSB first
RX_DATA  in  1  serial write data, LSB first
WRITE_EN  in  1  write request
READ_EN  in  1  read request
RX_BURST  in  1  burst request, sampled at transaction start
DATA_TX  out  1  serial read data, LSB first
SLAVE_READY  out  1  slave accepts a bit this cycle
SLAVE_VALID  out  1  DATA_TX valid

Behaviour:
- Clocking and reset: one clock CLK; RST is synchronous and active-high.
- Reset values: state=IDLE, DATA_TX=0, SLAVE_VALID=0, SLAVE_READY=1, counters and address=0. Memory contents are not reset.
- States: IDLE, ADDR, WDATA, WCOMMIT, RFETCH, RDATA.
- Bit transfer: an input bit transfers when M_VALID & SLAVE_READY. An output bit transfers when SLAVE_VALID & M_READY.
- IDLE (SLAVE_READY=1): on M_VALID & (WRITE_EN ^ READ_EN):
  - latch op and RX_BURST;
  - shift in address bit 0;
  - bit_cnt=1;
  - go to ADDR.
  - If WRITE_EN & READ_EN both high, or neither is high: stay in IDLE and capture nothing.
- ADDR (SLAVE_READY=1): shift RX_ADDR into addr[bit_cnt] on each transfer. After bit ADDR_W-1: write op goes to WDATA, read op goes to RFETCH; bit_cnt clears.
- WDATA (SLAVE_READY=1): shift RX_DATA LSB first. After DATA_W bits, go to WCOMMIT.
- WCOMMIT (SLAVE_READY=0, one cycle): write the word to mem[addr].
  - If burst is latched and M_VALID=1: addr=addr+1 modulo 2**ADDR_W, go to WDATA.
  - Otherwise go to IDLE.
- RFETCH (SLAVE_READY=0, one cycle): synchronous memory read; the read word loads the TX shift register. Go to RDATA.
- RDATA (SLAVE_READY=0, SLAVE_VALID=1): DATA_TX = shreg[0]; shift on each output transfer.
  - On transfer of bit DATA_W-1: if burst and M_VALID=1, addr+1 (wrap) and go to RFETCH; else go to IDLE with SLAVE_VALID=0 the next cycle.
- Latency:
  - write: ADDR_W+DATA_W transfer cycles + 1 commit cycle;
  - read: first DATA_TX bit valid 1 cycle after the last address bit transfers.
- Stalls: M_VALID=0 in ADDR/WDATA holds state and counters. M_READY=0 in RDATA holds DATA_TX.
- WRITE_EN/READ_EN are ignored after IDLE; the op latched at start governs.
- RST mid-transaction: abort to IDLE next cycle. A partial write is discarded (no memory write).
- Address wrap: 0xFFF+1 = 0x000 at ADDR_W=12.

Optional Feature:
- Macro SERIAL_SLAVE_PARITY_EN.
- When defined:
  - one even-parity bit follows the data word in both directions;
  - WDATA takes DATA_W+1 bits;
  - a write with bad parity skips the memory write (WCOMMIT still takes its cycle);
  - RDATA sends DATA_W+1 bits;
  - extra output PARITY_ERR (1 bit, reset 0) pulses high for one cycle in WCOMMIT on a mismatch.
- When undefined: no parity bits and no PARITY_ERR port.

Decomposition:
- Package serial_bus_pkg holds:
  - state enum ssp_state_t;
  - op enum ssp_op_t {OP_NONE, OP_WR, OP_RD};
  - localparams for default ADDR_W/DATA_W.
- One sub-module, serial_slave_mem: single-port synchronous RAM, 2**ADDR_W x DATA_W, 1-cycle read latency, write enable.
- The FSM and shift registers stay in the top module.

Test Plan:
- Single write then read: write 0xA5 to 0x123, then read 0x123 → DATA_TX bit sequence 1,0,1,0,0,1,0,1 with SLAVE_VALID high for 8 cycles; SLAVE_READY=0 in WCOMMIT.
- Burst write with wrap: start 0xFFE, RX_BURST=1, data 0x11/0x22/0x33 → then single reads return 0xFFE=0x11, 0xFFF=0x22, 0x000=0x33.
- Back-pressure: read 0x123 with M_READY toggling 1,0,0,1,... → DATA_TX holds during stall cycles; the full 0xA5 sequence is still correct. M_VALID gaps during ADDR yield the correct address.
- Illegal request: WRITE_EN=READ_EN=1 with M_VALID=1 → state stays IDLE, no memory change, SLAVE_VALID=0.
- Reset mid-write: assert RST after 5 data bits of a write of 0x7E to 0x010 → IDLE next cycle; reading 0x010 returns its prior value.
- Parity (macro on): write 0x03 with parity bit 1 (wrong) → PARITY_ERR pulses once and memory is unchanged; a correct parity bit of 0 → write occurs.
